// File: rtl/datapath_seq_pkg.sv
// Shared types and helpers for the self-sequencing datapath.
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_CMP  = 3'b011,
        OP_AND  = 3'b100,
        OP_MVN  = 3'b101
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    // Widest value sx() can produce; callers cast the result down to WIDTH.
    localparam int unsigned SX_W = 64;

    // Sign-extend the low imm_w bits of imm to SX_W bits.
    function automatic logic [SX_W-1:0] sx(input logic [SX_W-1:0] imm, input int unsigned imm_w);
        logic [SX_W-1:0] t;
        int unsigned     sh;
        sh = SX_W - imm_w;
        t  = imm << sh;
        return SX_W'($signed(t) >>> sh);
    endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Instruction request / completion bus between controller and datapath.
interface datapath_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned IMM_W = 8
);
    localparam int unsigned RW = $clog2(NREGS);

    logic             start;
    logic [2:0]       opcode;
    logic [RW-1:0]    rd;
    logic [RW-1:0]    rn;
    logic [RW-1:0]    rm;
    logic [1:0]       shift;
    logic [IMM_W-1:0] imm;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] datapath_out;
    logic             Z_out;
    logic             V_out;
    logic             N_out;

    modport master (
        output start, opcode, rd, rn, rm, shift, imm,
        input  busy, done, datapath_out, Z_out, V_out, N_out
    );

    modport slave (
        input  start, opcode, rd, rn, rm, shift, imm,
        output busy, done, datapath_out, Z_out, V_out, N_out
    );

endinterface

// File: rtl/dps_regfile.sv
// Register file: one synchronous write port, two combinational read ports.
module dps_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(NREGS)-1:0] rn_addr,
    input  logic [$clog2(NREGS)-1:0] rm_addr,
    output logic [WIDTH-1:0]         rn_data,
    output logic [WIDTH-1:0]         rm_data
);

    logic [WIDTH-1:0] regs [NREGS];

    // Storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rn_data = regs[rn_addr];
    assign rm_data = regs[rm_addr];

endmodule

// File: rtl/datapath_seq.sv
// Datapath with its own sequencer: one instruction per start handshake.
module datapath_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned IMM_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    datapath_seq_if.slave bus
);
    import datapath_seq_pkg::*;

    localparam int unsigned RW = $clog2(NREGS);

    state_e           state;
    logic [2:0]       ir_op;
    logic [RW-1:0]    ir_rd;
    logic [RW-1:0]    ir_rn;
    logic [RW-1:0]    ir_rm;
    logic [1:0]       ir_shift;
    logic [IMM_W-1:0] ir_imm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             z;
    logic             v;
    logic             n;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] rn_data;
    logic [WIDTH-1:0] rm_data;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             ovf;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    // Writeback happens only in WB; MOVI writes its immediate instead of C.
    assign wr_en   = (state == ST_WB);
    assign wr_data = (ir_op == OP_MOVI) ? WIDTH'(sx(SX_W'(ir_imm), IMM_W)) : c;

    dps_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (ir_rd),
        .wr_data (wr_data),
        .rn_addr (ir_rn),
        .rm_addr (ir_rm),
        .rn_data (rn_data),
        .rm_data (rm_data)
    );

    // Shifter on the B operand followed by the ALU and overflow detect.
    always_comb begin
        sb      = b;
        alu_res = '0;
        case (ir_shift)
            SH_LSL1: sb = {b[WIDTH-2:0], 1'b0};
            SH_LSR1: sb = {1'b0, b[WIDTH-1:1]};
            SH_ASR1: sb = {b[WIDTH-1], b[WIDTH-1:1]};
            default: sb = b;
        endcase
        diff = a - sb;
        ovf  = (a[WIDTH-1] != sb[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
        case (ir_op)
            OP_ADD:  alu_res = a + sb;
            OP_CMP:  alu_res = diff;
            OP_AND:  alu_res = a & sb;
            OP_MOV:  alu_res = sb;
            OP_MVN:  alu_res = ~sb;
            default: alu_res = '0;
        endcase
    end

    // Sequencer, instruction register, operand/result registers and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ir_op    <= '0;
            ir_rd    <= '0;
            ir_rn    <= '0;
            ir_rm    <= '0;
            ir_shift <= '0;
            ir_imm   <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            z        <= 1'b0;
            v        <= 1'b0;
            n        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        ir_op    <= bus.opcode;
                        ir_rd    <= bus.rd;
                        ir_rn    <= bus.rn;
                        ir_rm    <= bus.rm;
                        ir_shift <= bus.shift;
                        ir_imm   <= bus.imm;
                        case (bus.opcode)
                            OP_MOVI: begin
                                state <= ST_WB;
                                busy  <= 1'b1;
                            end
                            OP_MOV, OP_MVN: begin
                                state <= ST_LDB;
                                busy  <= 1'b1;
                            end
                            OP_ADD, OP_AND, OP_CMP: begin
                                state <= ST_LDA;
                                busy  <= 1'b1;
                            end
                            // Reserved opcodes complete immediately with no side effects.
                            default: done <= 1'b1;
                        endcase
                    end
                end
                ST_LDA: begin
                    a     <= rn_data;
                    state <= ST_LDB;
                end
                ST_LDB: begin
                    b     <= rm_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (ir_op == OP_CMP) begin
                        z     <= (diff == '0);
                        n     <= diff[WIDTH-1];
                        v     <= ovf;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        c     <= alu_res;
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.datapath_out = c;
    assign bus.Z_out        = z;
    assign bus.V_out        = v;
    assign bus.N_out        = n;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboarded random and directed bench for datapath_seq.
module tb_datapath_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    datapath_seq_if #(.WIDTH(16), .NREGS(8),  .IMM_W(8))  bif ();
    datapath_seq_if #(.WIDTH(32), .NREGS(16), .IMM_W(12)) bif32 ();

    datapath_seq #(.WIDTH(16), .NREGS(8), .IMM_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    datapath_seq #(.WIDTH(32), .NREGS(16), .IMM_W(12)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif32)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        string       name;
        logic [15:0] c;
        logic        z;
        logic        v;
        logic        n;
        int          done_edge;
    } exp_t;

    exp_t sb_q[$];

    // Architectural model: registers, C and flags as plain integers.
    int unsigned m_r[8];
    int unsigned m_c;
    bit          m_z, m_v, m_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned sx16(input int unsigned imm);
        int s;
        s = (imm >= 128) ? int'(imm) - 256 : int'(imm);
        return int'(s) & 32'hFFFF;
    endfunction

    function automatic int to_signed16(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic int unsigned shifted(input int unsigned x, input int unsigned sh);
        case (sh)
            0:       return x;
            1:       return (x * 2) % 65536;
            2:       return x / 2;
            default: return x / 2 + ((x >= 32768) ? 32768 : 0);
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_c = 0;
        m_z = 0;
        m_v = 0;
        m_n = 0;
    endfunction

    // Wait for idle, update the model, queue the expectation, drive one start pulse.
    task automatic issue(input int unsigned op, input int unsigned rd, input int unsigned rn,
                         input int unsigned rm, input int unsigned sh, input int unsigned imm);
        int guard = 0;
        int lat;
        int unsigned av, bv, d;
        int sd;
        exp_t e;
        while (bif.busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_wait: busy stuck at %0b required 0", bif.busy);
        end
        av = m_r[rn];
        bv = shifted(m_r[rm], sh);
        case (op)
            0: begin m_r[rd] = sx16(imm); lat = 2; end
            1: begin m_c = bv; m_r[rd] = m_c; lat = 4; end
            2: begin m_c = (av + bv) % 65536; m_r[rd] = m_c; lat = 5; end
            3: begin
                d   = (av + 65536 - bv) % 65536;
                sd  = to_signed16(av) - to_signed16(bv);
                m_z = (d == 0);
                m_n = (d >= 32768);
                m_v = (sd > 32767) || (sd < -32768);
                lat = 4;
            end
            4: begin m_c = av & bv; m_r[rd] = m_c; lat = 5; end
            5: begin m_c = 65535 - bv; m_r[rd] = m_c; lat = 4; end
            default: lat = 1;
        endcase
        e.name      = $sformatf("op%0d_rd%0d_rn%0d_rm%0d_sh%0d", op, rd, rn, rm, sh);
        e.c         = 16'(m_c);
        e.z         = m_z;
        e.v         = m_v;
        e.n         = m_n;
        e.done_edge = edge_cnt + lat;
        sb_q.push_back(e);
        bif.start  = 1'b1;
        bif.opcode = 3'(op);
        bif.rd     = 3'(rd);
        bif.rn     = 3'(rn);
        bif.rm     = 3'(rm);
        bif.shift  = 2'(sh);
        bif.imm    = 8'(imm);
        @(negedge clk);
        bif.start  = 1'b0;
        bif.opcode = 3'($urandom_range(0, 7));
        bif.rd     = 3'($urandom_range(0, 7));
        bif.rn     = 3'($urandom_range(0, 7));
        bif.rm     = 3'($urandom_range(0, 7));
        bif.shift  = 2'($urandom_range(0, 3));
        bif.imm    = 8'($urandom_range(0, 255));
    endtask

    // Monitor: every done pulse retires the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && bif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at edge %0d required no completion", edge_cnt);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_out"},     64'(bif.datapath_out), 64'(e.c));
                check({e.name, "_Z"},       64'(bif.Z_out), 64'(e.z));
                check({e.name, "_V"},       64'(bif.V_out), 64'(e.v));
                check({e.name, "_N"},       64'(bif.N_out), 64'(e.n));
                check({e.name, "_latency"}, 64'(edge_cnt), 64'(e.done_edge));
                check({e.name, "_busy"},    64'(bif.busy), 64'd0);
            end
        end
    end

    task automatic issue32(input int unsigned op, input int unsigned rd, input int unsigned rm,
                           input int unsigned sh, input int unsigned imm, output logic [31:0] out);
        int guard = 0;
        bif32.start  = 1'b1;
        bif32.opcode = 3'(op);
        bif32.rd     = 4'(rd);
        bif32.rn     = 4'd0;
        bif32.rm     = 4'(rm);
        bif32.shift  = 2'(sh);
        bif32.imm    = 12'(imm);
        @(negedge clk);
        bif32.start = 1'b0;
        while (bif32.done !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL w32_done_timeout: done=%0b required 1", bif32.done);
        end
        out = bif32.datapath_out;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] out32;
        int guard;
        bif.start = 1'b0; bif.opcode = '0; bif.rd = '0; bif.rn = '0; bif.rm = '0;
        bif.shift = '0; bif.imm = '0;
        bif32.start = 1'b0; bif32.opcode = '0; bif32.rd = '0; bif32.rn = '0; bif32.rm = '0;
        bif32.shift = '0; bif32.imm = '0;
        model_reset();

        // Reset asserted mid-cycle forces outputs low at once.
        #1 reset = 1'b1;
        #1;
        check("rst_out",  64'(bif.datapath_out), 64'd0);
        check("rst_busy", 64'(bif.busy), 64'd0);
        check("rst_done", 64'(bif.done), 64'd0);
        check("rst_flags", 64'({bif.Z_out, bif.V_out, bif.N_out}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(2, 0, 0, 0, 0, 0);             // ADD R0,R0,R0
        issue(0, 0, 0, 0, 0, 7);             // MOVI R0,#7
        issue(0, 1, 0, 0, 0, 8'hFE);         // MOVI R1,#-2
        issue(1, 2, 0, 1, 2, 0);             // MOV R2,R1,LSR
        issue(2, 3, 0, 1, 0, 0);             // ADD R3,R0,R1
        issue(4, 4, 1, 0, 0, 0);             // AND R4,R1,R0
        issue(5, 5, 0, 0, 0, 0);             // MVN R5,R0
        issue(0, 6, 0, 0, 0, 8'hFF);         // MOVI R6,#-1
        issue(3, 0, 2, 6, 0, 0);             // CMP R2,R6
        issue(3, 0, 0, 0, 0, 0);             // CMP R0,R0
        issue(6, 0, 0, 0, 0, 0);             // reserved
        issue(7, 1, 1, 1, 0, 0);             // reserved

        // A start while busy must be dropped.
        issue(2, 3, 0, 1, 0, 0);             // ADD R3,R0,R1
        bif.start = 1'b1; bif.opcode = 3'd0; bif.rd = 3'd3; bif.imm = 8'h55;
        @(negedge clk);
        bif.start = 1'b0;
        issue(1, 7, 0, 3, 0, 0);             // MOV R7,R3

        // Reset in LDB of an ADD: no completion, no writeback.
        guard = 0;
        while (bif.busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bif.start = 1'b1; bif.opcode = 3'd2; bif.rd = 3'd3; bif.rn = 3'd1; bif.rm = 3'd1;
        bif.shift = 2'd0;
        @(negedge clk);
        bif.start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_out",   64'(bif.datapath_out), 64'd0);
        check("midrst_busy",  64'(bif.busy), 64'd0);
        check("midrst_done",  64'(bif.done), 64'd0);
        check("midrst_flags", 64'({bif.Z_out, bif.V_out, bif.N_out}), 64'd0);
        model_reset();
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        issue(1, 7, 0, 3, 0, 0);             // MOV R7,R3

        // Randomized instruction stream.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d completions outstanding required 0", sb_q.size());
        end

        // Wide configuration: sign extension of a 12-bit immediate and ASR.
        issue32(0, 15, 0, 0, 12'h800, out32);   // MOVI R15,#0x800
        issue32(1, 13, 15, 0, 0, out32);        // MOV R13,R15
        check("w32_movi_sx", 64'(out32), 64'hFFFFF800);
        issue32(1, 14, 15, 3, 0, out32);        // MOV R14,R15,ASR
        check("w32_mov_asr", 64'(out32), 64'hFFFFFC00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
